lsq_issue_sched: RTL and testbench

- Per-entry issue scheduler for the sparse read buffer (SRB) load queue.
- Allocates entries in order at the write pointer supplied by lsq_ptr_gen.
- Tracks each entry's state and issues the oldest ready entry to the memory port using a valid/ready handshake.
- Frees entries out of order on memory response. It drives lsq_ptr_gen's w_req/r_req/entry_valid and consumes its w_ptr/bottom_ptr.

---
 rtl/lsq_issue_sched.sv | 211 +++++++++++++++++++++
 tb/tb_lsq_issue_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_issue_sched.sv
// lsq_issue_sched -- issue scheduler for the SRB load queue.
//
// Entries are allocated in order at w_ptr, which lsq_ptr_gen supplies. Each
// entry steps through FREE -> WAIT/RDY -> ISSUED -> FREE. Every cycle the
// oldest RDY entry, counted from bottom_ptr with wrap, is loaded into a
// registered valid/ready memory request. Entries are freed out of order when
// their memory response arrives.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   alloc_valid/alloc_rdy        allocation request; operands already ready
//   alloc_ready, alloc_ptr       allocation accepted; index of allocated slot
//   wake_valid, wake_ptr         operand-ready notification for a WAIT entry
//   mem_req_valid/ready/ptr      registered memory request handshake
//   mem_resp_valid, mem_resp_ptr memory response (frees an ISSUED entry)
//   w_req_valid                  to lsq_ptr_gen: advance w_ptr
//   r_req_valid, r_req_ptr       to lsq_ptr_gen: entry freed
//   entry_valid                  to lsq_ptr_gen: per-entry non-FREE flags
//   w_ptr, bottom_ptr            from lsq_ptr_gen: write slot, oldest slot
//   occ_cnt                      number of non-FREE entries
//   resp_err                     sticky: response to an entry not in ISSUED

// Per-entry state machine. The four request strobes are qualified here
// against the current state, so the caller may assert them unconditionally.
module lsq_issue_entry (
  input  logic clk,
  input  logic rst_n,
  input  logic alloc_i,
  input  logic alloc_rdy_i,
  input  logic wake_i,
  input  logic issue_i,
  input  logic free_i,
  output logic valid_o,
  output logic rdy_o,
  output logic issued_o
);
  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RDY    = 2'd2,
    ST_ISSUED = 2'd3
  } st_e;

  st_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FREE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FREE:   if (alloc_i) state_d = alloc_rdy_i ? ST_RDY : ST_WAIT;
      ST_WAIT:   if (wake_i)  state_d = ST_RDY;
      ST_RDY:    if (issue_i) state_d = ST_ISSUED;
      ST_ISSUED: if (free_i)  state_d = ST_FREE;
      default:   state_d = ST_FREE;
    endcase
  end

  assign valid_o  = (state_q != ST_FREE);
  assign rdy_o    = (state_q == ST_RDY);
  assign issued_o = (state_q == ST_ISSUED);
endmodule

module lsq_issue_sched #(
  parameter  int SRB_DEPTH       = 8,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int PTR_W           = $clog2(SRB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_valid,
  input  logic                 alloc_rdy,
  output logic                 alloc_ready,
  output logic [PTR_W-1:0]     alloc_ptr,
  input  logic                 wake_valid,
  input  logic [PTR_W-1:0]     wake_ptr,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [PTR_W-1:0]     mem_req_ptr,
  input  logic                 mem_resp_valid,
  input  logic [PTR_W-1:0]     mem_resp_ptr,
  output logic                 w_req_valid,
  output logic                 r_req_valid,
  output logic [PTR_W-1:0]     r_req_ptr,
  output logic [SRB_DEPTH-1:0] entry_valid,
  input  logic [PTR_W-1:0]     w_ptr,
  input  logic [PTR_W-1:0]     bottom_ptr,
  output logic [PTR_W:0]       occ_cnt,
  output logic                 resp_err
);
  localparam logic [PTR_W:0] MAX_OUT = (PTR_W+1)'(MAX_OUTSTANDING);

  logic [SRB_DEPTH-1:0] is_vld, is_rdy, is_iss;
  logic [SRB_DEPTH-1:0] alloc_en, wake_en, issue_en, free_en;

  logic                 mem_req_valid_q, mem_req_valid_d;
  logic [PTR_W-1:0]     mem_req_ptr_q, mem_req_ptr_d;
  logic [PTR_W:0]       out_q, out_d;
  logic [PTR_W:0]       occ_q, occ_d;
  logic                 err_q, err_d;

  logic                 alloc_fire, resp_ok, held_hit, load;
  logic                 pick_found;
  logic [PTR_W-1:0]     pick_ptr, scan_idx;

  // Allocation is strictly in order: only slot w_ptr is ever considered.
  assign alloc_ready = ~is_vld[w_ptr];
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_ptr   = w_ptr;
  assign w_req_valid = alloc_fire;

  // A response to the entry still sitting unaccepted in the request
  // register is a protocol error even though that entry is ISSUED.
  assign held_hit    = mem_req_valid_q & (mem_req_ptr_q == mem_resp_ptr);
  assign resp_ok     = mem_resp_valid & is_iss[mem_resp_ptr] & ~held_hit;
  assign r_req_valid = resp_ok;
  assign r_req_ptr   = mem_resp_ptr;

  // Oldest-first select: walk from bottom_ptr upward, wrapping naturally in
  // PTR_W bits. The held entry is ISSUED already, but it is excluded
  // explicitly so the pick never aliases the register contents.
  always_comb begin
    pick_found = 1'b0;
    pick_ptr   = '0;
    scan_idx   = '0;
    for (int k = 0; k < SRB_DEPTH; k++) begin
      scan_idx = bottom_ptr + PTR_W'(k);
      if (!pick_found && is_rdy[scan_idx] &&
          !(mem_req_valid_q && scan_idx == mem_req_ptr_q)) begin
        pick_found = 1'b1;
        pick_ptr   = scan_idx;
      end
    end
  end

  // The outstanding count already includes the entry in the request
  // register, so the cap bounds issued-but-unanswered entries overall.
  assign load = (~mem_req_valid_q | mem_req_ready) & pick_found & (out_q < MAX_OUT);

  for (genvar g = 0; g < SRB_DEPTH; g++) begin : g_ent
    assign alloc_en[g] = alloc_fire & (w_ptr == PTR_W'(g));
    assign wake_en[g]  = wake_valid & (wake_ptr == PTR_W'(g));
    assign issue_en[g] = load & (pick_ptr == PTR_W'(g));
    assign free_en[g]  = resp_ok & (mem_resp_ptr == PTR_W'(g));

    lsq_issue_entry u_ent (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc_i    (alloc_en[g]),
      .alloc_rdy_i(alloc_rdy),
      .wake_i     (wake_en[g]),
      .issue_i    (issue_en[g]),
      .free_i     (free_en[g]),
      .valid_o    (is_vld[g]),
      .rdy_o      (is_rdy[g]),
      .issued_o   (is_iss[g])
    );
  end

  always_comb begin
    mem_req_valid_d = mem_req_valid_q;
    mem_req_ptr_d   = mem_req_ptr_q;
    if (load) begin
      mem_req_valid_d = 1'b1;
      mem_req_ptr_d   = pick_ptr;
    end else if (mem_req_ready) begin
      mem_req_valid_d = 1'b0;
    end

    out_d = out_q;
    case ({load, resp_ok})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    occ_d = occ_q;
    case ({alloc_fire, resp_ok})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    err_d = err_q | (mem_resp_valid & ~resp_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_valid_q <= 1'b0;
      mem_req_ptr_q   <= '0;
      out_q           <= '0;
      occ_q           <= '0;
      err_q           <= 1'b0;
    end else begin
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_ptr_q   <= mem_req_ptr_d;
      out_q           <= out_d;
      occ_q           <= occ_d;
      err_q           <= err_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_ptr   = mem_req_ptr_q;
  assign entry_valid   = is_vld;
  assign occ_cnt       = occ_q;
  assign resp_err      = err_q;
endmodule

// File: tb/tb_lsq_issue_sched.sv
// Testbench for lsq_issue_sched: directed scenarios plus a randomized run
// checked against an entry-array reference model. The bench also plays
// lsq_ptr_gen (w_ptr / bottom_ptr) from the model's view of the queue.
module tb_lsq_issue_sched;
  localparam int D    = 8;
  localparam int MAXO = 4;
  localparam int SF = 0, SW = 1, SR = 2, SI = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic alloc_valid = 0, alloc_rdy = 0, alloc_ready;
  logic [2:0] alloc_ptr;
  logic wake_valid = 0;
  logic [2:0] wake_ptr = '0;
  logic mem_req_valid, mem_req_ready = 0;
  logic [2:0] mem_req_ptr;
  logic mem_resp_valid = 0;
  logic [2:0] mem_resp_ptr = '0;
  logic w_req_valid, r_req_valid;
  logic [2:0] r_req_ptr;
  logic [D-1:0] entry_valid;
  logic [2:0] w_ptr, bottom_ptr;
  logic [3:0] occ_cnt;
  logic resp_err;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  lsq_issue_sched dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_rdy(alloc_rdy),
    .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
    .wake_valid(wake_valid), .wake_ptr(wake_ptr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_ptr(mem_req_ptr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ptr(mem_resp_ptr),
    .w_req_valid(w_req_valid), .r_req_valid(r_req_valid), .r_req_ptr(r_req_ptr),
    .entry_valid(entry_valid), .w_ptr(w_ptr), .bottom_ptr(bottom_ptr),
    .occ_cnt(occ_cnt), .resp_err(resp_err)
  );

  // Reference model: one state per entry, request register, counters.
  int m_st [D];
  bit m_vld, m_err;
  int m_ptr, m_out, m_occ;

  function automatic bit f_alloc();
    return alloc_valid && m_st[w_ptr] == SF;
  endfunction

  function automatic int f_pick();
    for (int k = 0; k < D; k++) begin
      int idx;
      idx = (int'(bottom_ptr) + k) % D;
      if (m_st[idx] == SR && !(m_vld && m_ptr == idx)) return idx;
    end
    return -1;
  endfunction

  function automatic bit f_load();
    return (!m_vld || mem_req_ready) && f_pick() >= 0 && m_out < MAXO;
  endfunction

  function automatic bit f_free();
    return mem_resp_valid && m_st[mem_resp_ptr] == SI &&
           !(m_vld && m_ptr == int'(mem_resp_ptr));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) m_st[i] <= SF;
      m_vld <= 0; m_ptr <= 0; m_out <= 0; m_occ <= 0; m_err <= 0;
      w_ptr <= '0; bottom_ptr <= '0;
    end else begin
      if (f_alloc()) m_st[w_ptr] <= alloc_rdy ? SR : SW;
      if (wake_valid && m_st[wake_ptr] == SW) m_st[wake_ptr] <= SR;
      if (f_load()) begin
        m_st[f_pick()] <= SI; m_vld <= 1; m_ptr <= f_pick();
      end else if (mem_req_ready) m_vld <= 0;
      if (f_free()) m_st[mem_resp_ptr] <= SF;
      m_out <= m_out + int'(f_load()) - int'(f_free());
      m_occ <= m_occ + int'(f_alloc()) - int'(f_free());
      if (mem_resp_valid && !f_free()) m_err <= 1;
      if (f_alloc()) w_ptr <= w_ptr + 3'd1;
      if (m_st[bottom_ptr] == SF && bottom_ptr != w_ptr) bottom_ptr <= bottom_ptr + 3'd1;
    end
  end

  task automatic do_reset();
    alloc_valid = 0; alloc_rdy = 0; wake_valid = 0; wake_ptr = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_ptr = '0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset mem_req_valid got=%b exp=0", mem_req_valid); end
    n_cmp++; if (mem_req_ptr !== 3'd0) begin n_bad++; $display("FAIL reset mem_req_ptr got=%0d exp=0", mem_req_ptr); end
    n_cmp++; if (occ_cnt !== 4'd0) begin n_bad++; $display("FAIL reset occ_cnt got=%0d exp=0", occ_cnt); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset resp_err got=%b exp=0", resp_err); end
    n_cmp++; if (entry_valid !== 8'h00) begin n_bad++; $display("FAIL reset entry_valid got=%h exp=00", entry_valid); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset alloc_ready got=%b exp=1", alloc_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_issue();
    int acc[$];
    do_reset();
    mem_req_ready = 1;
    for (int c = 0; c < 14; c++) begin
      alloc_valid = (c < 8); alloc_rdy = 1;
      @(negedge clk);
      if (c < 8) begin
        n_cmp++; if (alloc_ptr !== 3'(c) || alloc_ready !== 1'b1) begin
          n_bad++; $display("FAIL fill alloc c=%0d got ptr=%0d rdy=%b exp ptr=%0d rdy=1", c, alloc_ptr, alloc_ready, c); end
      end
      if (mem_req_valid && mem_req_ready) acc.push_back(int'(mem_req_ptr));
      @(posedge clk); #1;
    end
    alloc_valid = 0;
    @(negedge clk);
    n_cmp++; if (acc.size() != 4) begin n_bad++; $display("FAIL fill issue_count got=%0d exp=4", acc.size()); end
    for (int i = 0; i < acc.size() && i < 4; i++) begin
      n_cmp++; if (acc[i] != i) begin n_bad++; $display("FAIL fill issue_order i=%0d got=%0d exp=%0d", i, acc[i], i); end
    end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL fill alloc_ready got=%b exp=0", alloc_ready); end
    n_cmp++; if (occ_cnt !== 4'd8) begin n_bad++; $display("FAIL fill occ_cnt got=%0d exp=8", occ_cnt); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL fill capped mem_req_valid got=%b exp=0", mem_req_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_wake_resp();
    do_reset();
    mem_req_ready = 1;
    for (int c = 0; c < 3; c++) begin
      alloc_valid = 1; alloc_rdy = 0;
      @(posedge clk); #1;
    end
    alloc_valid = 0;
    wake_valid = 1; wake_ptr = 3'd2;
    @(posedge clk); #1;
    wake_valid = 0;
    @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL wake early_valid got=%b exp=0", mem_req_valid); end
    wake_valid = 1; wake_ptr = 3'd0;
    @(posedge clk); #1;
    wake_valid = 0;
    @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_ptr !== 3'd2) begin
      n_bad++; $display("FAIL wake first_issue got v=%b p=%0d exp v=1 p=2", mem_req_valid, mem_req_ptr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_ptr !== 3'd0) begin
      n_bad++; $display("FAIL wake second_issue got v=%b p=%0d exp v=1 p=0", mem_req_valid, mem_req_ptr); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (mem_req_valid !== 1'b0) begin
        n_bad++; $display("FAIL wake entry1_issued c=%0d got v=%b p=%0d exp v=0", c, mem_req_valid, mem_req_ptr); end
    end
    @(posedge clk); #1;
    mem_resp_valid = 1; mem_resp_ptr = 3'd2;
    @(negedge clk);
    n_cmp++; if (r_req_valid !== 1'b1 || r_req_ptr !== 3'd2) begin
      n_bad++; $display("FAIL resp r_req_2 got v=%b p=%0d exp v=1 p=2", r_req_valid, r_req_ptr); end
    @(posedge clk); #1;
    mem_resp_ptr = 3'd0;
    @(negedge clk);
    n_cmp++; if (r_req_valid !== 1'b1 || r_req_ptr !== 3'd0) begin
      n_bad++; $display("FAIL resp r_req_0 got v=%b p=%0d exp v=1 p=0", r_req_valid, r_req_ptr); end
    n_cmp++; if (entry_valid !== 8'h03 || occ_cnt !== 4'd2) begin
      n_bad++; $display("FAIL resp after_2 got ev=%h occ=%0d exp ev=03 occ=2", entry_valid, occ_cnt); end
    @(posedge clk); #1;
    mem_resp_valid = 0;
    @(negedge clk);
    n_cmp++; if (entry_valid !== 8'h02 || occ_cnt !== 4'd1 || resp_err !== 1'b0) begin
      n_bad++; $display("FAIL resp after_0 got ev=%h occ=%0d err=%b exp ev=02 occ=1 err=0", entry_valid, occ_cnt, resp_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    do_reset();
    mem_req_ready = 0;
    for (int c = 0; c < 5; c++) begin
      alloc_valid = 1; alloc_rdy = (c >= 3);
      @(posedge clk); #1;
    end
    alloc_valid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_ptr !== 3'd3) begin
        n_bad++; $display("FAIL hold c=%0d got v=%b p=%0d exp v=1 p=3", c, mem_req_valid, mem_req_ptr); end
      @(posedge clk); #1;
    end
    mem_req_ready = 1;
    @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_ptr !== 3'd3) begin
      n_bad++; $display("FAIL hold accept got v=%b p=%0d exp v=1 p=3", mem_req_valid, mem_req_ptr); end
    @(posedge clk); #1;
    mem_req_ready = 0;
    @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_ptr !== 3'd4) begin
      n_bad++; $display("FAIL hold next_pick got v=%b p=%0d exp v=1 p=4", mem_req_valid, mem_req_ptr); end
    @(posedge clk); #1;
  endtask

  task automatic test_inorder_alloc();
    do_reset();
    mem_req_ready = 1;
    for (int c = 0; c < 8; c++) begin
      alloc_valid = 1; alloc_rdy = (c == 0 || c == 5);
      @(posedge clk); #1;
    end
    alloc_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    mem_resp_valid = 1; mem_resp_ptr = 3'd5;
    @(negedge clk);
    n_cmp++; if (r_req_valid !== 1'b1 || r_req_ptr !== 3'd5) begin
      n_bad++; $display("FAIL inorder r_req_5 got v=%b p=%0d exp v=1 p=5", r_req_valid, r_req_ptr); end
    @(posedge clk); #1;
    mem_resp_valid = 0;
    @(negedge clk);
    n_cmp++; if (alloc_ready !== 1'b0 || entry_valid !== 8'hDF || occ_cnt !== 4'd7) begin
      n_bad++; $display("FAIL inorder blocked got rdy=%b ev=%h occ=%0d exp rdy=0 ev=df occ=7", alloc_ready, entry_valid, occ_cnt); end
    @(posedge clk); #1;
    mem_resp_valid = 1; mem_resp_ptr = 3'd0;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    @(negedge clk);
    n_cmp++; if (alloc_ready !== 1'b1 || alloc_ptr !== 3'd0 || occ_cnt !== 4'd6) begin
      n_bad++; $display("FAIL inorder unblocked got rdy=%b ptr=%0d occ=%0d exp rdy=1 ptr=0 occ=6", alloc_ready, alloc_ptr, occ_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_err_reset();
    do_reset();
    mem_resp_valid = 1; mem_resp_ptr = 3'd6;
    @(negedge clk);
    n_cmp++; if (r_req_valid !== 1'b0) begin n_bad++; $display("FAIL err r_req_valid got=%b exp=0", r_req_valid); end
    @(posedge clk); #1;
    mem_resp_valid = 0;
    @(negedge clk);
    n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL err resp_err got=%b exp=1", resp_err); end
    @(posedge clk); #1;
    mem_req_ready = 1;
    for (int c = 0; c < 3; c++) begin
      alloc_valid = 1; alloc_rdy = 1;
      @(posedge clk); #1;
    end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0 || mem_req_ptr !== 3'd0 || occ_cnt !== 4'd0 ||
                 resp_err !== 1'b0 || entry_valid !== 8'h00) begin
      n_bad++; $display("FAIL async_reset got v=%b p=%0d occ=%0d err=%b ev=%h exp all zero",
                        mem_req_valid, mem_req_ptr, occ_cnt, resp_err, entry_valid); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      int cand[$];
      logic [D-1:0] e_ev;
      bit e_free;
      alloc_valid   = ($urandom_range(0, 99) < 50);
      alloc_rdy     = $urandom_range(0, 1);
      wake_valid    = ($urandom_range(0, 99) < 40);
      wake_ptr      = 3'($urandom_range(0, D-1));
      mem_req_ready = ($urandom_range(0, 99) < 60);
      for (int i = 0; i < D; i++)
        if (m_st[i] == SI && !(m_vld && m_ptr == i)) cand.push_back(i);
      mem_resp_valid = 0;
      if (cand.size() > 0 && $urandom_range(0, 99) < 45) begin
        mem_resp_valid = 1; mem_resp_ptr = 3'(cand[$urandom_range(0, cand.size()-1)]);
      end else if ($urandom_range(0, 99) < 2) begin
        mem_resp_valid = 1; mem_resp_ptr = 3'($urandom_range(0, D-1));
      end
      @(negedge clk);
      for (int i = 0; i < D; i++) e_ev[i] = (m_st[i] != SF);
      e_free = f_free();
      n_cmp++; if (alloc_ready !== (m_st[w_ptr] == SF)) begin n_bad++; $display("FAIL rnd alloc_ready c=%0d got=%b exp=%b", c, alloc_ready, m_st[w_ptr] == SF); end
      n_cmp++; if (w_req_valid !== f_alloc()) begin n_bad++; $display("FAIL rnd w_req_valid c=%0d got=%b exp=%b", c, w_req_valid, f_alloc()); end
      n_cmp++; if (mem_req_valid !== m_vld) begin n_bad++; $display("FAIL rnd mem_req_valid c=%0d got=%b exp=%b", c, mem_req_valid, m_vld); end
      if (m_vld) begin
        n_cmp++; if (mem_req_ptr !== 3'(m_ptr)) begin n_bad++; $display("FAIL rnd mem_req_ptr c=%0d got=%0d exp=%0d", c, mem_req_ptr, m_ptr); end
      end
      n_cmp++; if (r_req_valid !== e_free) begin n_bad++; $display("FAIL rnd r_req_valid c=%0d got=%b exp=%b", c, r_req_valid, e_free); end
      if (e_free) begin
        n_cmp++; if (r_req_ptr !== mem_resp_ptr) begin n_bad++; $display("FAIL rnd r_req_ptr c=%0d got=%0d exp=%0d", c, r_req_ptr, mem_resp_ptr); end
      end
      n_cmp++; if (entry_valid !== e_ev) begin n_bad++; $display("FAIL rnd entry_valid c=%0d got=%h exp=%h", c, entry_valid, e_ev); end
      n_cmp++; if (occ_cnt !== 4'(m_occ)) begin n_bad++; $display("FAIL rnd occ_cnt c=%0d got=%0d exp=%0d", c, occ_cnt, m_occ); end
      n_cmp++; if (resp_err !== m_err) begin n_bad++; $display("FAIL rnd resp_err c=%0d got=%b exp=%b", c, resp_err, m_err); end
      @(posedge clk); #1;
    end
    alloc_valid = 0; wake_valid = 0; mem_resp_valid = 0;
  endtask

  initial begin
    test_reset();
    test_fill_issue();
    test_wake_resp();
    test_hold();
    test_inorder_alloc();
    test_err_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
